// File: rtl/vector_mem_sequencer.sv
// Splits one vector load/store into per-lane scalar accesses at strided addresses; lane k issued at cycle k+1.
// Store done at vl+1, load done at vl+2; no backpressure from memory, busyM stalls the pipeline front while active.
module vector_mem_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      startM,
    input  logic                      isStoreM,
    input  logic [ADDR_W-1:0]         baseM,
    input  logic [ADDR_W-1:0]         strideM,
    input  logic [$clog2(LANES):0]    vlM,
    input  logic [LANES*DATA_W-1:0]   wdVecM,
    output logic                      memWriteOut,
    output logic [ADDR_W-1:0]         addrOut,
    output logic [DATA_W-1:0]         wdOut,
    input  logic [DATA_W-1:0]         rdIn,
    output logic [LANES*DATA_W-1:0]   rdVecOut,
    output logic                      busyM,
    output logic                      doneM
);

    localparam int IDX_W = $clog2(LANES);
    localparam int VL_W  = $clog2(LANES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    lane;
    logic [IDX_W-1:0]    lane_nxt;
    logic [IDX_W-1:0]    cap_idx;
    logic                cap_vld;
    logic [VL_W-1:0]     vl_q;
    logic [VL_W-1:0]     vl_clamp;
    logic                is_store;
    logic                last_lane;
    logic [ADDR_W-1:0]   stride_q;
    logic [ADDR_W-1:0]   next_addr;
    logic [DATA_W-1:0]   wd_in   [LANES];
    logic [DATA_W-1:0]   wd_lane [LANES];
    logic [DATA_W-1:0]   rd_lane [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign wd_in[g]                       = wdVecM[g*DATA_W +: DATA_W];
        assign rdVecOut[g*DATA_W +: DATA_W]   = rd_lane[g];
    end

    always_comb begin
        vl_clamp = vlM;
        if (vlM > VL_W'(LANES)) begin
            vl_clamp = VL_W'(LANES);
        end
    end

    assign last_lane = (({1'b0, lane} + VL_W'(1)) == vl_q);
    assign lane_nxt  = lane + IDX_W'(1);

    assign busyM = (state != IDLE) || startM;
    assign doneM = (state == DONE);

    // Outputs for lane k are registered one edge ahead so lane k is on the bus in cycle k+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lane        <= '0;
            cap_idx     <= '0;
            cap_vld     <= 1'b0;
            vl_q        <= '0;
            is_store    <= 1'b0;
            stride_q    <= '0;
            next_addr   <= '0;
            memWriteOut <= 1'b0;
            addrOut     <= '0;
            wdOut       <= '0;
            for (int i = 0; i < LANES; i++) begin
                rd_lane[i] <= '0;
                wd_lane[i] <= '0;
            end
        end else begin
            cap_vld     <= 1'b0;
            memWriteOut <= 1'b0;
            addrOut     <= '0;
            wdOut       <= '0;

            // Read data lags its address by one cycle, so capture uses the delayed lane index.
            if (cap_vld) begin
                rd_lane[cap_idx] <= rdIn;
            end

            case (state)
                IDLE: begin
                    if (startM) begin
                        is_store  <= isStoreM;
                        vl_q      <= vl_clamp;
                        stride_q  <= strideM;
                        lane      <= '0;
                        next_addr <= baseM + strideM;
                        for (int i = 0; i < LANES; i++) begin
                            wd_lane[i] <= wd_in[i];
                        end
                        if (vl_clamp == '0) begin
                            state <= DONE;
                        end else begin
                            state       <= ISSUE;
                            memWriteOut <= isStoreM;
                            addrOut     <= baseM;
                            wdOut       <= isStoreM ? wd_in[0] : '0;
                            if (!isStoreM) begin
                                for (int i = 0; i < LANES; i++) begin
                                    rd_lane[i] <= '0;
                                end
                            end
                        end
                    end
                end
                ISSUE: begin
                    cap_vld <= !is_store;
                    cap_idx <= lane;
                    if (last_lane) begin
                        state <= is_store ? DONE : DRAIN;
                    end else begin
                        lane        <= lane_nxt;
                        memWriteOut <= is_store;
                        addrOut     <= next_addr;
                        wdOut       <= is_store ? wd_lane[lane_nxt] : '0;
                        next_addr   <= next_addr + stride_q;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Bench: per-cycle scoreboard from a lane-arithmetic model plus hand-computed directed checks.
module tb_vector_mem_sequencer;

    localparam int LANES = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          startM = 1'b0;
    logic          isStoreM = 1'b0;
    logic [31:0]   baseM = '0;
    logic [31:0]   strideM = '0;
    logic [2:0]    vlM = '0;
    logic [127:0]  wdVecM = '0;
    logic [31:0]   rdIn = '0;
    logic          memWriteOut;
    logic [31:0]   addrOut;
    logic [31:0]   wdOut;
    logic [127:0]  rdVecOut;
    logic          busyM;
    logic          doneM;

    vector_mem_sequencer #(.LANES(4), .DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .startM(startM), .isStoreM(isStoreM),
        .baseM(baseM), .strideM(strideM), .vlM(vlM), .wdVecM(wdVecM),
        .memWriteOut(memWriteOut), .addrOut(addrOut), .wdOut(wdOut),
        .rdIn(rdIn), .rdVecOut(rdVecOut), .busyM(busyM), .doneM(doneM)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    // Environment memory: 1-cycle read latency, writes from the DUT bus.
    logic [31:0] emem [logic [31:0]];
    int wr_cnt = 0;
    always @(posedge clk) begin
        if (!rst) begin
            rdIn <= emem.exists(addrOut) ? emem[addrOut] : dflt(addrOut);
            if (memWriteOut) begin
                emem[addrOut] = wdOut;
                wr_cnt++;
            end
        end
    end

    // Model: expected bus contents per absolute cycle, filled when a start is accepted.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        done;
    } exp_t;

    exp_t         sched [int];
    logic [31:0]  mmem [logic [31:0]];
    int           done_cyc = -1;
    bit           armed = 1'b0;
    logic [127:0] rv_cur = '0;
    logic [127:0] rv_next = '0;
    int           rv_switch = 1 << 30;
    int           blind_lo = 0;
    int           blind_hi = -1;

    task automatic model_accept();
        int v;
        int c;
        logic [31:0] a;
        logic [31:0] ln;
        logic [127:0] res;
        exp_t e;
        c = cyc;
        v = (vlM > 3'd4) ? 4 : int'(vlM);
        res = '0;
        if (v == 0) begin
            e.we = 1'b0; e.addr = '0; e.wd = '0; e.done = 1'b1;
            sched[c + 1] = e;
            done_cyc = c + 1;
        end else begin
            for (int k = 0; k < v; k++) begin
                a  = baseM + strideM * 32'(k);
                ln = wdVecM[k*32 +: 32];
                e.we = isStoreM; e.addr = a; e.wd = isStoreM ? ln : 32'd0; e.done = 1'b0;
                sched[c + 1 + k] = e;
                if (isStoreM) mmem[a] = ln;
                else res[k*32 +: 32] = mmem.exists(a) ? mmem[a] : dflt(a);
            end
            done_cyc = isStoreM ? c + v + 1 : c + v + 2;
            e.we = 1'b0; e.addr = '0; e.wd = '0; e.done = 1'b1;
            sched[done_cyc] = e;
            if (!isStoreM) begin
                blind_lo  = c + 1;
                blind_hi  = c + v + 1;
                rv_next   = res;
                rv_switch = c + v + 2;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int keys[$];
        e.we = 1'b0; e.addr = '0; e.wd = '0; e.done = 1'b0;
        if (sched.exists(cyc)) e = sched[cyc];
        if (armed) begin
            chk("we", memWriteOut, e.we);
            chk("addr", addrOut, e.addr);
            chk("wd", wdOut, e.wd);
            chk("done", doneM, e.done);
            chk("busy", busyM, (cyc <= done_cyc) || startM);
            if (cyc >= rv_switch) begin
                rv_cur = rv_next;
                rv_switch = 1 << 30;
            end
            if (!(cyc >= blind_lo && cyc <= blind_hi)) chk("rdvec", rdVecOut, rv_cur);
        end
        if (rst) begin
            armed = 1'b1;
            foreach (sched[k]) if (k > cyc) keys.push_back(k);
            foreach (keys[j]) sched.delete(keys[j]);
            done_cyc  = cyc;
            rv_next   = '0;
            rv_switch = cyc + 1;
            blind_hi  = cyc;
        end else if (startM && cyc > done_cyc) begin
            model_accept();
        end
    end

    task automatic at_cycle(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic issue(input logic st, input logic [31:0] b, input logic [31:0] s,
                         input logic [2:0] v, input logic [127:0] wv, output int c0);
        @(posedge clk); #1;
        startM = 1'b1; isStoreM = st; baseM = b; strideM = s; vlM = v; wdVecM = wv;
        c0 = cyc;
        @(negedge clk);
        chk("start_busy", busyM, 1'b1);
        @(posedge clk); #1;
        startM = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busyM !== 1'b0 && n < 50);
        if (busyM !== 1'b0) chk("idle_timeout", busyM, 1'b0);
    endtask

    initial begin
        int c;
        int w0;
        logic [127:0] st_vec;
        st_vec = {32'd999, 32'd222, 32'd45, 32'd33};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busyM, 1'b0);
        chk("rst_addr", addrOut, 32'd0);
        chk("rst_rdvec", rdVecOut, 128'd0);
        chk("rst_done", doneM, 1'b0);

        issue(1'b1, 32'd8505, 32'd1, 3'd3, st_vec, c);
        at_cycle(c + 1);
        chk("st_a0", addrOut, 32'd8505); chk("st_w0", wdOut, 32'd33); chk("st_we0", memWriteOut, 1'b1);
        at_cycle(c + 2);
        chk("st_a1", addrOut, 32'd8506); chk("st_w1", wdOut, 32'd45);
        at_cycle(c + 3);
        chk("st_a2", addrOut, 32'd8507); chk("st_w2", wdOut, 32'd222);
        at_cycle(c + 4);
        chk("st_done", doneM, 1'b1); chk("st_busy4", busyM, 1'b1);
        wait_idle();

        issue(1'b0, 32'd8505, 32'd1, 3'd3, '0, c);
        at_cycle(c + 5);
        chk("ld_done", doneM, 1'b1);
        at_cycle(c + 6);
        chk("ld_vec", rdVecOut, {32'd0, 32'd222, 32'd45, 32'd33});
        wait_idle();

        issue(1'b0, 32'd1, 32'hFFFF_FFFF, 3'd4, '0, c);
        at_cycle(c + 1); chk("wrap_a0", addrOut, 32'd1);
        at_cycle(c + 2); chk("wrap_a1", addrOut, 32'd0);
        at_cycle(c + 3); chk("wrap_a2", addrOut, 32'hFFFF_FFFF);
        at_cycle(c + 4); chk("wrap_a3", addrOut, 32'hFFFF_FFFE);
        wait_idle();

        w0 = wr_cnt;
        issue(1'b1, 32'h100, 32'd3, 3'd7, {32'd7, 32'd6, 32'd5, 32'd4}, c);
        at_cycle(c + 4); chk("clamp_a3", addrOut, 32'h109);
        at_cycle(c + 5); chk("clamp_done", doneM, 1'b1);
        wait_idle();
        chk("clamp_writes", 128'(wr_cnt - w0), 128'd4);

        issue(1'b0, 32'h100, 32'd0, 3'd2, '0, c);
        at_cycle(c + 5);
        chk("stride0_vec", rdVecOut, {32'd0, 32'd0, 32'd4, 32'd4});
        wait_idle();

        issue(1'b0, 32'd8505, 32'd1, 3'd2, '0, c);
        wait_idle();
        w0 = wr_cnt;
        issue(1'b0, 32'd8505, 32'd1, 3'd0, '0, c);
        at_cycle(c + 1); chk("noop_done", doneM, 1'b1); chk("noop_we", memWriteOut, 1'b0);
        at_cycle(c + 2); chk("noop_vec", rdVecOut, {32'd0, 32'd0, 32'd45, 32'd33});
        wait_idle();

        @(posedge clk); #1;
        startM = 1'b1; isStoreM = 1'b1; baseM = 32'h200; strideM = 32'd2; vlM = 3'd2;
        wdVecM = {32'd0, 32'd0, 32'd12, 32'd11};
        c = cyc;
        at_cycle(c + 3); chk("b2b_done1", doneM, 1'b1);
        at_cycle(c + 4); chk("b2b_busy", busyM, 1'b1); chk("b2b_gap_we", memWriteOut, 1'b0);
        at_cycle(c + 5); chk("b2b_a0", addrOut, 32'h200); chk("b2b_w0", wdOut, 32'd11);
        at_cycle(c + 9);
        @(posedge clk); #1;
        startM = 1'b0;
        wait_idle();

        issue(1'b0, 32'd8505, 32'd1, 3'd4, '0, c);
        at_cycle(c + 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", busyM, 1'b0); chk("rstmid_addr", addrOut, 32'd0);
        chk("rstmid_vec", rdVecOut, 128'd0); chk("rstmid_done", doneM, 1'b0);
        repeat (4) @(negedge clk);

        issue(1'b0, 32'd8505, 32'd1, 3'd3, '0, c);
        at_cycle(c + 6);
        chk("reload_vec", rdVecOut, {32'd0, 32'd222, 32'd45, 32'd33});
        wait_idle();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
